// File: rtl/denoise_pkg.sv
// ---------------------------------------------------------------------------
// denoise_pkg
// Shared definitions for the denoise pipeline blocks.
//   - collector_state_t : outlier_collector FSM states (IDLE/RUN/FLUSH/DONE)
//   - DEFAULT_N            : default index / address / counter width
//   - DEFAULT_MAX_OUTLIERS : default result RAM depth
// ---------------------------------------------------------------------------
package denoise_pkg;

  localparam int DEFAULT_N            = 16;
  localparam int DEFAULT_MAX_OUTLIERS = 4096;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_RUN   = 2'd1,
    ST_FLUSH = 2'd2,
    ST_DONE  = 2'd3
  } collector_state_t;

endpackage

// File: rtl/outlier_collector_fifo_pop_stage.sv
// ---------------------------------------------------------------------------
// fifo_pop_stage
// Pops a standard (non-FWFT) FIFO and presents a valid/data pair one cycle
// after each pop request.
// Ports:
//   clock, reset  : rising-edge clock, asynchronous active-high reset
//   run           : collector is in RUN; popping is allowed
//   fifo_empty    : FIFO empty flag
//   fifo_dout     : FIFO read data (valid the cycle after fifo_rd_en)
//   fifo_rd_en    : FIFO pop request (combinational)
//   pop_valid     : pop_data carries a popped index this cycle (rd_v)
//   pop_data      : popped index
// ---------------------------------------------------------------------------
module fifo_pop_stage #(
  parameter int N = 16
) (
  input  logic         clock,
  input  logic         reset,
  input  logic         run,
  input  logic         fifo_empty,
  input  logic [N-1:0] fifo_dout,
  output logic         fifo_rd_en,
  output logic         pop_valid,
  output logic [N-1:0] pop_data
);

  logic rd_v_reg;

  // Pop every cycle that data exists; the upstream controller never stalls.
  assign fifo_rd_en = run && !fifo_empty;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      rd_v_reg <= 1'b0;
    end else begin
      rd_v_reg <= fifo_rd_en;
    end
  end

  // The FIFO's own output register is the data half of this stage: its
  // dout is stable for exactly the cycle in which rd_v is high.
  assign pop_valid = rd_v_reg;
  assign pop_data  = fifo_dout;

endmodule

// File: rtl/outlier_collector.sv
// ---------------------------------------------------------------------------
// outlier_collector
// Drains the validation controller's outlier FIFO into a result RAM, counts
// the entries, and signals completion once the controller is done and the
// FIFO and read pipeline are empty.
// Ports:
//   clock, reset      : rising-edge clock, asynchronous active-high reset
//   start             : one-cycle pulse, accepted in IDLE or DONE only
//   ctrl_done         : controller finished validation (level)
//   point_cloud_size  : cloud size, used only by the optional range check
//   fifo_dout/empty   : FIFO read port inputs
//   fifo_rd_en        : FIFO pop request
//   mem_we/addr/wdata : registered result RAM write port
//   outlier_count     : number of entries written
//   busy, done        : RUN/FLUSH, DONE
//   overflow          : sticky, an entry was dropped because the RAM was full
//   range_err         : sticky, an index >= point_cloud_size was seen
// Build option:
//   OUTLIER_COLLECTOR_RANGE_CHECK_EN : drop out-of-range indices and flag
//   range_err; when undefined, range_err is tied low.
// ---------------------------------------------------------------------------
module outlier_collector
  import denoise_pkg::*;
#(
  parameter int N            = DEFAULT_N,
  parameter int MAX_OUTLIERS = DEFAULT_MAX_OUTLIERS
) (
  input  logic           clock,
  input  logic           reset,
  input  logic           start,
  input  logic           ctrl_done,
  input  logic [2*N-1:0] point_cloud_size,
  input  logic [N-1:0]   fifo_dout,
  input  logic           fifo_empty,
  output logic           fifo_rd_en,
  output logic           mem_we,
  output logic [N-1:0]   mem_addr,
  output logic [N-1:0]   mem_wdata,
  output logic [N-1:0]   outlier_count,
  output logic           busy,
  output logic           done,
  output logic           overflow,
  output logic           range_err
);

  // Counter is one bit wider than N so MAX_OUTLIERS == 2^N is representable.
  localparam logic [N:0] MAX_L = (N+1)'(MAX_OUTLIERS);
  localparam logic [N:0] ONE_L = {{N{1'b0}}, 1'b1};

  collector_state_t state_reg, state_next;

  logic         pop_valid;
  logic [N-1:0] pop_data;

  logic [N:0]   count_reg;
  logic         mem_we_reg;
  logic [N-1:0] mem_addr_reg;
  logic [N-1:0] mem_wdata_reg;
  logic         overflow_reg;

  logic start_accept;
  logic in_range;
  logic has_room;
  logic accept;
  logic drop_full;

  // ---------------------------------------------------------------------
  // Stage 1: FIFO pop and rd_v register
  // ---------------------------------------------------------------------
  fifo_pop_stage #(
    .N (N)
  ) u_pop (
    .clock      (clock),
    .reset      (reset),
    .run        (state_reg == ST_RUN),
    .fifo_empty (fifo_empty),
    .fifo_dout  (fifo_dout),
    .fifo_rd_en (fifo_rd_en),
    .pop_valid  (pop_valid),
    .pop_data   (pop_data)
  );

  // ---------------------------------------------------------------------
  // FSM
  // ---------------------------------------------------------------------
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_reg <= ST_IDLE;
    end else begin
      state_reg <= state_next;
    end
  end

  always_comb begin
    state_next   = state_reg;
    start_accept = 1'b0;
    unique case (state_reg)
      ST_IDLE: begin
        if (start) begin
          state_next   = ST_RUN;
          start_accept = 1'b1;
        end
      end
      ST_RUN: begin
        // Leave only once nothing is queued and nothing is in flight, so
        // every popped index reaches stage 2 before DONE.
        if (ctrl_done && fifo_empty && !pop_valid) begin
          state_next = ST_FLUSH;
        end
      end
      ST_FLUSH: begin
        // One cycle for the final registered write to retire.
        state_next = ST_DONE;
      end
      ST_DONE: begin
        if (start) begin
          state_next   = ST_RUN;
          start_accept = 1'b1;
        end
      end
      default: begin
        state_next = ST_IDLE;
      end
    endcase
  end

  // ---------------------------------------------------------------------
  // Stage 2: accept / drop decision
  // ---------------------------------------------------------------------
`ifdef OUTLIER_COLLECTOR_RANGE_CHECK_EN
  assign in_range = ({{N{1'b0}}, pop_data} < point_cloud_size);
`else
  assign in_range = 1'b1;
  wire unused_point_cloud_size = ^point_cloud_size;
`endif

  assign has_room  = (count_reg < MAX_L);
  assign accept    = pop_valid && in_range && has_room;
  assign drop_full = pop_valid && in_range && !has_room;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      mem_we_reg    <= 1'b0;
      mem_addr_reg  <= '0;
      mem_wdata_reg <= '0;
      count_reg     <= '0;
      overflow_reg  <= 1'b0;
    end else begin
      mem_we_reg <= accept;
      if (accept) begin
        mem_addr_reg  <= count_reg[N-1:0];
        mem_wdata_reg <= pop_data;
      end
      // start is only accepted in IDLE/DONE, where the pipe is empty, so a
      // clear never collides with a write.
      if (start_accept) begin
        count_reg    <= '0;
        overflow_reg <= 1'b0;
      end else begin
        if (accept) begin
          count_reg <= count_reg + ONE_L;
        end
        if (drop_full) begin
          overflow_reg <= 1'b1;
        end
      end
    end
  end

`ifdef OUTLIER_COLLECTOR_RANGE_CHECK_EN
  logic range_err_reg;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      range_err_reg <= 1'b0;
    end else if (start_accept) begin
      range_err_reg <= 1'b0;
    end else if (pop_valid && !in_range) begin
      range_err_reg <= 1'b1;
    end
  end

  assign range_err = range_err_reg;
`else
  assign range_err = 1'b0;
`endif

  // ---------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------
  assign mem_we        = mem_we_reg;
  assign mem_addr      = mem_addr_reg;
  assign mem_wdata     = mem_wdata_reg;
  assign outlier_count = count_reg[N-1:0];
  assign overflow      = overflow_reg;
  assign busy          = (state_reg == ST_RUN) || (state_reg == ST_FLUSH);
  assign done          = (state_reg == ST_DONE);

endmodule

// File: tb/tb_outlier_collector.sv
// ---------------------------------------------------------------------------
// tb_outlier_collector
// Randomised scoreboard bench for outlier_collector. A queue-based FIFO
// model feeds the DUT; a list-level reference model predicts the sequence
// of RAM writes and the final count/flags; a monitor compares every write.
// Honours OUTLIER_COLLECTOR_RANGE_CHECK_EN the same way the design does.
// ---------------------------------------------------------------------------
module tb_outlier_collector;

  localparam int N    = 16;
  localparam int MAXO = 8;

  logic           clock = 1'b0;
  logic           reset;
  logic           start;
  logic           ctrl_done;
  logic [2*N-1:0] point_cloud_size;
  logic [N-1:0]   fifo_dout;
  logic           fifo_empty;
  logic           fifo_rd_en;
  logic           mem_we;
  logic [N-1:0]   mem_addr;
  logic [N-1:0]   mem_wdata;
  logic [N-1:0]   outlier_count;
  logic           busy;
  logic           done;
  logic           overflow;
  logic           range_err;

  outlier_collector #(
    .N            (N),
    .MAX_OUTLIERS (MAXO)
  ) dut (
    .clock            (clock),
    .reset            (reset),
    .start            (start),
    .ctrl_done        (ctrl_done),
    .point_cloud_size (point_cloud_size),
    .fifo_dout        (fifo_dout),
    .fifo_empty       (fifo_empty),
    .fifo_rd_en       (fifo_rd_en),
    .mem_we           (mem_we),
    .mem_addr         (mem_addr),
    .mem_wdata        (mem_wdata),
    .outlier_count    (outlier_count),
    .busy             (busy),
    .done             (done),
    .overflow         (overflow),
    .range_err        (range_err)
  );

  always #5 clock = ~clock;

  int checks = 0;
  int errors = 0;

  // ---------------- FIFO model ----------------
  logic         push_en;
  logic [N-1:0] push_data;
  logic [N-1:0] fq[$];
  int           pops;

  always @(posedge clock or posedge reset) begin
    if (reset) begin
      fq.delete();
      pops = 0;
      fifo_empty <= 1'b1;
      fifo_dout  <= '0;
    end else begin
      if (fifo_rd_en) begin
        checks++;
        if (fq.size() == 0) begin
          errors++;
          $display("FAIL pop_when_empty: fifo_rd_en=1 with fifo size 0, required rd_en=0");
        end else begin
          fifo_dout <= fq.pop_front();
          pops = pops + 1;
        end
      end
      if (push_en) fq.push_back(push_data);
      fifo_empty <= (fq.size() == 0);
    end
  end

  // ---------------- reference model ----------------
  typedef struct packed {
    logic [N-1:0] addr;
    logic [N-1:0] data;
  } wr_t;

  wr_t exp_q[$];
  int  m_count;
  bit  m_ovf;
  bit  m_rerr;
  int  m_pushes;
  int  pops_base;

  task automatic model_clear();
    exp_q.delete();
    m_count   = 0;
    m_ovf     = 1'b0;
    m_rerr    = 1'b0;
    m_pushes  = 0;
    pops_base = pops;
  endtask

  // Each pushed index is eventually popped in order; decide its fate here.
  task automatic model_add(input logic [N-1:0] v);
    bit ok;
    wr_t w;
`ifdef OUTLIER_COLLECTOR_RANGE_CHECK_EN
    ok = (int'(v) < int'(point_cloud_size));
`else
    ok = 1'b1;
`endif
    m_pushes++;
    if (!ok) begin
      m_rerr = 1'b1;
    end else if (m_count < MAXO) begin
      w.addr = m_count[N-1:0];
      w.data = v;
      exp_q.push_back(w);
      m_count++;
    end else begin
      m_ovf = 1'b1;
    end
  endtask

  // ---------------- monitor ----------------
  always @(negedge clock) begin
    if (!reset && mem_we) begin
      wr_t e;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_write: addr=%0d data=%0d, no write expected", mem_addr, mem_wdata);
      end else begin
        e = exp_q.pop_front();
        if (mem_addr !== e.addr || mem_wdata !== e.data) begin
          errors++;
          $display("FAIL mem_write: got (%0d,%0d) expected (%0d,%0d)", mem_addr, mem_wdata, e.addr, e.data);
        end else begin
          $display("write addr=%0d data=%0d ok", mem_addr, mem_wdata);
        end
      end
    end
  end

  // ---------------- helpers ----------------
  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end else begin
      $display("check %s = %0d ok", name, act);
    end
  endtask

  task automatic push_one(input logic [N-1:0] v);
    push_en   = 1'b1;
    push_data = v;
    model_add(v);
    @(negedge clock);
    push_en   = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
  endtask

  task automatic wait_done(input int limit);
    int n;
    n = 0;
    while (!done && n < limit) begin
      @(negedge clock);
      n++;
    end
    checks++;
    if (!done) begin
      errors++;
      $display("FAIL done_timeout: done=0 after %0d cycles, required 1", limit);
    end
  endtask

  task automatic finish_run(input string tag);
    ctrl_done = 1'b1;
    wait_done(200);
    check({tag, "_count"}, 32'(outlier_count), 32'(m_count));
    check({tag, "_overflow"}, 32'(overflow), 32'(m_ovf));
    check({tag, "_range_err"}, 32'(range_err), 32'(m_rerr));
    check({tag, "_pending_writes"}, 32'(exp_q.size()), 32'd0);
    check({tag, "_pops"}, 32'(pops - pops_base), 32'(m_pushes));
    check({tag, "_busy"}, 32'(busy), 32'd0);
    ctrl_done = 1'b0;
  endtask

  task automatic check_reset_outputs(input string tag);
    check({tag, "_rd_en"}, 32'(fifo_rd_en), 32'd0);
    check({tag, "_mem_we"}, 32'(mem_we), 32'd0);
    check({tag, "_mem_addr"}, 32'(mem_addr), 32'd0);
    check({tag, "_mem_wdata"}, 32'(mem_wdata), 32'd0);
    check({tag, "_count"}, 32'(outlier_count), 32'd0);
    check({tag, "_busy"}, 32'(busy), 32'd0);
    check({tag, "_done"}, 32'(done), 32'd0);
    check({tag, "_overflow"}, 32'(overflow), 32'd0);
    check({tag, "_range_err"}, 32'(range_err), 32'd0);
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- stimulus ----------------
  initial begin
    int rd_first, rd_last, rd_cnt, we_first, we_last, we_cnt, n;

    reset            = 1'b1;
    start            = 1'b0;
    ctrl_done        = 1'b0;
    push_en          = 1'b0;
    push_data        = '0;
    point_cloud_size = 32'd100;
    repeat (2) @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check_reset_outputs("reset");
    model_clear();

    // Basic
    point_cloud_size = 32'd100;
    pulse_start();
    push_one(16'd5);
    push_one(16'd9);
    push_one(16'd12);
    finish_run("basic");

    // Back-to-back from a preloaded FIFO
    model_clear();
    point_cloud_size = 32'd1000;
    for (int i = 0; i < 8; i++) push_one(16'(i * 3 + 1));
    @(negedge clock);
    check("b2b_no_pop_in_done", 32'(fifo_rd_en), 32'd0);
    rd_first = -1; rd_last = -1; rd_cnt = 0;
    we_first = -1; we_last = -1; we_cnt = 0;
    start = 1'b1;
    @(negedge clock);
    start = 1'b0;
    for (int c = 0; c < 14; c++) begin
      if (fifo_rd_en) begin
        if (rd_first < 0) rd_first = c;
        rd_last = c;
        rd_cnt++;
      end
      if (mem_we) begin
        if (we_first < 0) we_first = c;
        we_last = c;
        we_cnt++;
      end
      @(negedge clock);
    end
    check("b2b_rd_count", 32'(rd_cnt), 32'd8);
    check("b2b_rd_span", 32'(rd_last - rd_first + 1), 32'd8);
    check("b2b_we_count", 32'(we_cnt), 32'd8);
    check("b2b_we_span", 32'(we_last - we_first + 1), 32'd8);
    check("b2b_we_latency", 32'(we_first - rd_first), 32'd2);
    finish_run("b2b");

    // Overflow: more entries than the RAM holds
    model_clear();
    for (int i = 0; i < 11; i++) push_one(16'(100 + i));
    pulse_start();
    finish_run("overflow");

    // Range check boundary: 3, 10, 7 with size 10
    model_clear();
    point_cloud_size = 32'd10;
    pulse_start();
    push_one(16'd3);
    push_one(16'd10);
    push_one(16'd7);
    finish_run("range");

    // Randomised runs
    for (int r = 0; r < 6; r++) begin
      model_clear();
      point_cloud_size = 32'($urandom_range(5, 40));
      pulse_start();
      n = $urandom_range(0, 12);
      for (int i = 0; i < n; i++) begin
        repeat ($urandom_range(0, 2)) @(negedge clock);
        push_one(16'($urandom_range(0, 47)));
      end
      finish_run($sformatf("rand%0d", r));
    end

    // Empty run: done exactly two cycles after entering RUN
    model_clear();
    ctrl_done = 1'b1;
    pulse_start();
    check("empty_run_busy", 32'(busy), 32'd1);
    @(negedge clock);
    check("empty_flush_done", 32'(done), 32'd0);
    @(negedge clock);
    check("empty_done", 32'(done), 32'd1);
    check("empty_count", 32'(outlier_count), 32'd0);
    ctrl_done = 1'b0;

    // Reset mid-run after two writes
    model_clear();
    point_cloud_size = 32'd1000;
    for (int i = 0; i < 5; i++) push_one(16'(40 + i));
    pulse_start();
    n = 0;
    while (outlier_count != 16'd2 && n < 20) begin
      @(negedge clock);
      n++;
    end
    check("midrun_reached_two", 32'(outlier_count), 32'd2);
    #2;
    reset = 1'b1;
    #1;
    check_reset_outputs("midrun_reset");
    exp_q.delete();
    @(negedge clock);
    reset = 1'b0;
    @(negedge clock);
    check("after_reset_done", 32'(done), 32'd0);

    // Start ignored while RUN
    model_clear();
    pulse_start();
    push_one(16'd21);
    push_one(16'd22);
    repeat (4) @(negedge clock);
    check("ignore_pre_count", 32'(outlier_count), 32'd2);
    pulse_start();
    @(negedge clock);
    check("ignore_post_count", 32'(outlier_count), 32'd2);
    check("ignore_post_busy", 32'(busy), 32'd1);
    finish_run("ignore");

    // Restart from DONE clears the count
    model_clear();
    pulse_start();
    check("restart_count", 32'(outlier_count), 32'd0);
    check("restart_busy", 32'(busy), 32'd1);
    finish_run("restart");

    repeat (2) @(negedge clock);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
